fpu_result_arbiter: RTL and testbench

FPU_RESULT_ARBITER -- requirements
Module: fpu_result_arbiter

---
 rtl/fpu_result_arbiter.sv | 145 ++++++++++++++
 tb/tb_fpu_result_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_arbiter
// Purpose  : Merges the arithmetic-pipeline and load-completion writeback
//            requesters onto a single registered XIF result port. Ties are
//            broken round-robin; the output register is a one-entry slot
//            that can be refilled in the same cycle it is drained.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_arbiter #(
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  enable,

  input  logic                  pipe_valid,
  output logic                  pipe_ready,
  input  logic [X_ID_WIDTH-1:0] pipe_id,
  input  logic [4:0]            pipe_rd,
  input  logic [FLEN-1:0]       pipe_data,

  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [X_ID_WIDTH-1:0] ld_id,
  input  logic [4:0]            ld_rd,
  input  logic [FLEN-1:0]       ld_data,

  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [4:0]            result_rd,
  output logic [FLEN-1:0]       result_data,
  output logic                  result_is_load,

  output logic [7:0]            stall_cnt
);

  // Output-slot occupancy
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Requester identity, used for last_grant and result_is_load
  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_LD   = 1'b1;

  localparam logic [7:0] STALL_MAX = 8'hFF;

  logic [0:0]            state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic [X_ID_WIDTH-1:0] id_q,         id_d;
  logic [4:0]            rd_q,         rd_d;
  logic [FLEN-1:0]       data_q,       data_d;
  logic                  is_load_q,    is_load_d;
  logic [7:0]            stall_cnt_q,  stall_cnt_d;

  logic slot_free;
  logic can_grant;
  logic grant_pipe;
  logic grant_ld;

  // Grant decision: the slot is free when empty or being drained this cycle.
  // rst is folded in so both readies are held low throughout reset.
  always_comb begin
    slot_free  = (state_q == ST_EMPTY) || result_ready;
    can_grant  = rst && enable && slot_free;
    grant_pipe = can_grant && pipe_valid &&
                 (!ld_valid || (last_grant_q == SRC_LD));
    grant_ld   = can_grant && ld_valid &&
                 (!pipe_valid || (last_grant_q == SRC_PIPE));
  end

  assign pipe_ready = grant_pipe;
  assign ld_ready   = grant_ld;

  // Next state of the output register: load the winner, drain, or hold.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rd_d         = rd_q;
    data_d       = data_q;
    is_load_d    = is_load_q;

    if (grant_pipe) begin
      state_d      = ST_FULL;
      last_grant_d = SRC_PIPE;
      id_d         = pipe_id;
      rd_d         = pipe_rd;
      data_d       = pipe_data;
      is_load_d    = SRC_PIPE;
    end else if (grant_ld) begin
      state_d      = ST_FULL;
      last_grant_d = SRC_LD;
      id_d         = ld_id;
      rd_d         = ld_rd;
      data_d       = ld_data;
      is_load_d    = SRC_LD;
    end else if ((state_q == ST_FULL) && result_ready) begin
      // Drained with nothing to replace it; payload is left as-is since
      // it is not observable while result_valid is low.
      state_d = ST_EMPTY;
    end
  end

  // Back-pressure counter: one count per cycle a presented result waits.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_FULL) && !result_ready && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  // State registers with asynchronous active-low clear; last_grant resets
  // to the load side so the pipe wins the first tie.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= SRC_LD;
      id_q         <= '0;
      rd_q         <= '0;
      data_q       <= '0;
      is_load_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      is_load_q    <= is_load_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign result_valid   = (state_q == ST_FULL);
  assign result_id      = id_q;
  assign result_rd      = rd_q;
  assign result_data    = data_q;
  assign result_is_load = is_load_q;
  assign stall_cnt      = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_arbiter
// Purpose  : Scoreboard bench for fpu_result_arbiter. Directed scenarios
//            followed by randomized traffic, checked against a queue-based
//            reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_arbiter;

  localparam int XW = 4;
  localparam int FL = 32;

  logic          ck = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          pipe_valid = 1'b0, pipe_ready;
  logic [XW-1:0] pipe_id = '0;
  logic [4:0]    pipe_rd = '0;
  logic [FL-1:0] pipe_data = '0;
  logic          ld_valid = 1'b0, ld_ready;
  logic [XW-1:0] ld_id = '0;
  logic [4:0]    ld_rd = '0;
  logic [FL-1:0] ld_data = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [XW-1:0] result_id;
  logic [4:0]    result_rd;
  logic [FL-1:0] result_data;
  logic          result_is_load;
  logic [7:0]    stall_cnt;

  fpu_result_arbiter #(.X_ID_WIDTH(XW), .FLEN(FL)) dut (
    .ck(ck), .rst(rst), .enable(enable),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_id(pipe_id),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_id(ld_id),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_rd(result_rd), .result_data(result_data),
    .result_is_load(result_is_load), .stall_cnt(stall_cnt)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [XW-1:0] id;
    logic [4:0]    rd;
    logic [FL-1:0] data;
    logic          is_load;
  } res_t;

  res_t q[$];          // results accepted but not yet consumed, grant order
  bit   m_last = 1'b1; // 1 = load was granted last
  int   m_stall = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: evaluates the model mid-cycle when inputs are stable.
  always @(negedge ck) begin
    if (!rst) begin
      chk("rst_valid", {63'd0, result_valid}, 64'd0);
      chk("rst_pipe_ready", {63'd0, pipe_ready}, 64'd0);
      chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
      chk("rst_stall", {56'd0, stall_cnt}, 64'd0);
      q.delete();
      m_last  = 1'b1;
      m_stall = 0;
    end else begin
      bit   free, exp_p, exp_l;
      res_t r;
      free  = (q.size() == 0) || result_ready;
      exp_p = enable && free && pipe_valid && (!ld_valid || m_last);
      exp_l = enable && free && ld_valid && (!pipe_valid || !m_last);
      chk("pipe_ready", {63'd0, pipe_ready}, {63'd0, exp_p});
      chk("ld_ready", {63'd0, ld_ready}, {63'd0, exp_l});
      chk("result_valid", {63'd0, result_valid}, {63'd0, q.size() != 0});
      chk("stall_cnt", {56'd0, stall_cnt}, 64'(m_stall));
      if (q.size() != 0) begin
        chk("result_id", 64'(result_id), 64'(q[0].id));
        chk("result_rd", 64'(result_rd), 64'(q[0].rd));
        chk("result_data", 64'(result_data), 64'(q[0].data));
        chk("result_is_load", 64'(result_is_load), 64'(q[0].is_load));
        if (!result_ready) begin
          if (m_stall < 255) m_stall++;
        end else begin
          void'(q.pop_front());
        end
      end
      if (exp_p) begin
        r = '{id: pipe_id, rd: pipe_rd, data: pipe_data, is_load: 1'b0};
        q.push_back(r);
        m_last = 1'b0;
      end else if (exp_l) begin
        r = '{id: ld_id, rd: ld_rd, data: ld_data, is_load: 1'b1};
        q.push_back(r);
        m_last = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input bit pv, input bit lv, input bit rr, input bit en);
    pipe_valid   = pv;
    ld_valid     = lv;
    result_ready = rr;
    enable       = en;
    pipe_id      = XW'($urandom);
    pipe_rd      = 5'($urandom);
    pipe_data    = $urandom;
    ld_id        = XW'($urandom);
    ld_rd        = 5'($urandom);
    ld_data      = $urandom;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single pipe request
    drive(1, 0, 1, 1);
    pipe_id = 4'd3; pipe_rd = 5'd5; pipe_data = 32'h3F80_0000;
    #1 chk("single_pipe_ready", {63'd0, pipe_ready}, 64'd1);
    step();
    drive(0, 0, 1, 1);
    chk("single_valid", {63'd0, result_valid}, 64'd1);
    chk("single_id", 64'(result_id), 64'd3);
    chk("single_data", 64'(result_data), 64'h3F80_0000);
    step(); step();

    // Tie round-robin from reset: pipe, ld, pipe, ld, ...
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 1);
      #1 chk("tie_pipe_ready", {63'd0, pipe_ready}, {63'd0, (i % 2) == 0});
      step();
      if (i > 0) chk("tie_valid", {63'd0, result_valid}, 64'd1);
    end
    drive(0, 0, 1, 1);
    step(); step();

    // Back-pressure for 300 cycles with a waiting load
    drive(1, 0, 1, 1);
    step();
    drive(0, 1, 0, 1);
    for (int i = 0; i < 300; i++) begin
      #1 chk("bp_ld_ready", {63'd0, ld_ready}, 64'd0);
      step();
      #0;
    end
    chk("bp_stall_sat", {56'd0, stall_cnt}, 64'd255);
    result_ready = 1'b1;
    #1 chk("bp_ld_granted", {63'd0, ld_ready}, 64'd1);
    step();
    drive(0, 0, 1, 1);
    step(); step();

    // Enable gating: held result drains while enable=0 blocks the pipe
    drive(1, 0, 0, 1);
    step();
    drive(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("en_pipe_blocked", {63'd0, pipe_ready}, 64'd0);
      step();
    end
    chk("en_drained", {63'd0, result_valid}, 64'd0);
    enable = 1'b1;
    #1 chk("en_pipe_resume", {63'd0, pipe_ready}, 64'd1);
    step();
    drive(0, 0, 1, 1);
    step(); step();

    // Reset mid-operation while holding id=7
    drive(1, 0, 0, 1);
    pipe_id = 4'd7;
    step();
    drive(0, 0, 0, 1);
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("async_valid", {63'd0, result_valid}, 64'd0);
    chk("async_stall", {56'd0, stall_cnt}, 64'd0);
    step(); step();
    rst = 1'b1;
    drive(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_id7", {63'd0, result_valid}, 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9);
      step();
    end
    drive(0, 0, 1, 1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
